cpu_boot_loader: RTL

//  Upstream control stage for the multicycle CPU. It owns CPU reset and clk_en, and muxes the main-memory

---
 rtl/cpu_boot_loader.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/cpu_boot_loader.sv
// cpu_boot_loader: host-facing control stage for the multicycle CPU.
// Loads a program word stream into main memory, then runs, single-steps
// or halts the CPU by driving its reset and clock enable. While loading,
// the memory write port belongs to the host stream; otherwise the CPU owns it.
module cpu_boot_loader #(
    parameter logic [31:0] BASE_ADDR  = 32'h0,
    parameter int unsigned MAX_WORDS  = 256,
    parameter int unsigned MAX_CYCLES = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        host_start,
    input  logic [15:0] host_nwords,
    input  logic [31:0] host_wdata,
    input  logic        host_wvalid,
    output logic        host_wready,
    input  logic        host_run,
    input  logic        host_step,
    input  logic        host_halt,
    input  logic        cpu_wr_en,
    input  logic [31:0] cpu_mem_addr,
    input  logic [31:0] cpu_w_data,
    output logic        cpu_rst,
    output logic        cpu_clk_en,
    output logic        mem_wr_en,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_w_data,
    output logic [15:0] load_count,
    output logic [31:0] cycle_count,
    output logic [2:0]  state_o,
    output logic        done
);

    localparam int unsigned CNT_W   = 16;
    localparam int unsigned CYC_W   = 32;
    localparam logic [CNT_W-1:0] MAX_W = CNT_W'(MAX_WORDS);
    localparam logic [CYC_W-1:0] MAX_C = CYC_W'(MAX_CYCLES);
    localparam logic [CYC_W-1:0] CYC_SAT = {CYC_W{1'b1}};

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_READY = 3'd2,
        S_RUN   = 3'd3,
        S_STEP  = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t           state;
    state_t           state_n;
    logic [CNT_W-1:0] load_count_n;
    logic [CYC_W-1:0] cycle_count_n;
    logic [CNT_W-1:0] nwords_q;
    logic [CNT_W-1:0] nwords_n;
    logic [CNT_W-1:0] nwords_clamped;
    logic [CNT_W-1:0] load_inc;
    logic [CYC_W-1:0] cycle_inc;
    logic             limit_hit;
    logic             beat;

    assign beat           = host_wvalid & host_wready;
    assign nwords_clamped = (host_nwords > MAX_W) ? MAX_W : host_nwords;
    assign load_inc       = CNT_W'(load_count + CNT_W'(1));
    assign cycle_inc      = (cycle_count == CYC_SAT) ? cycle_count
                                                     : CYC_W'(cycle_count + CYC_W'(1));
    assign limit_hit      = (MAX_C != '0) && (cycle_inc == MAX_C);
    assign state_o        = state;

    // Next-state and counter updates; host_start overrides everything.
    always_comb begin
        state_n       = state;
        load_count_n  = load_count;
        cycle_count_n = cycle_count;
        nwords_n      = nwords_q;
        if (host_start) begin
            load_count_n  = '0;
            cycle_count_n = '0;
            nwords_n      = nwords_clamped;
            state_n       = (nwords_clamped != '0) ? S_LOAD : S_READY;
        end else begin
            case (state)
                S_IDLE: ;
                S_LOAD: begin
                    if (beat) begin
                        load_count_n = load_inc;
                        if (load_inc == nwords_q) state_n = S_READY;
                    end
                end
                S_READY: begin
                    if (host_halt)      state_n = S_READY;
                    else if (host_run)  state_n = S_RUN;
                    else if (host_step) state_n = S_STEP;
                end
                S_RUN: begin
                    cycle_count_n = cycle_inc;
                    if (limit_hit)      state_n = S_DONE;
                    else if (host_halt) state_n = S_READY;
                end
                S_STEP: begin
                    cycle_count_n = cycle_inc;
                    state_n       = limit_hit ? S_DONE : S_READY;
                end
                S_DONE: ;
                default: state_n = S_IDLE;
            endcase
        end
    end

    // State, counters and state-decoded control outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            load_count  <= '0;
            cycle_count <= '0;
            nwords_q    <= '0;
            cpu_rst     <= 1'b1;
            cpu_clk_en  <= 1'b0;
            host_wready <= 1'b0;
            done        <= 1'b0;
        end else begin
            state       <= state_n;
            load_count  <= load_count_n;
            cycle_count <= cycle_count_n;
            nwords_q    <= nwords_n;
            cpu_rst     <= (state_n == S_IDLE) || (state_n == S_LOAD);
            cpu_clk_en  <= (state_n == S_RUN) || (state_n == S_STEP);
            host_wready <= (state_n == S_LOAD);
            done        <= (state_n == S_DONE);
        end
    end

    // Memory write-port mux: host stream while loading, CPU otherwise.
    always_comb begin
        mem_wr_en  = cpu_wr_en;
        mem_addr   = cpu_mem_addr;
        mem_w_data = cpu_w_data;
        if (state == S_LOAD) begin
            mem_wr_en  = beat;
            mem_addr   = BASE_ADDR + 32'({load_count, 2'b00});
            mem_w_data = host_wdata;
        end
    end

endmodule
